// File: rtl/switch_debounce.sv
// Per-bit switch debouncer with two-flop input synchronizers, a synchronized
// reset release, registered change/rise pulses and an optional sticky
// rising-edge event latch (built when SWITCH_DB_EVENT_LATCH_EN is defined).
module switch_debounce #(
  parameter int unsigned WIDTH    = 7,
  parameter int unsigned DB_LIMIT = 100000,
  parameter int unsigned CNT_W    = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] switch,
  output logic             changed,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] evt_bits,
  output logic             evt_valid,
  input  logic             evt_ack
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DB_LIMIT - 1);

  logic                        rst_meta_n;
  logic                        rst_int_n;
  logic [WIDTH-1:0]            sync_meta;
  logic [WIDTH-1:0]            sync;
  logic [WIDTH-1:0][CNT_W-1:0] cnt;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0]            upd;

  // Reset asserts immediately, releases two clocks after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_n <= 1'b0;
      rst_int_n  <= 1'b0;
    end else begin
      rst_meta_n <= 1'b1;
      rst_int_n  <= rst_meta_n;
    end
  end

  // Input synchronizers run off the raw reset so they fill during release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= sw_raw;
      sync      <= sync_meta;
    end
  end

  // Per-bit stability counters; a bit updates once it has differed long enough
  always_comb begin
    cnt_next = '0;
    upd      = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sync[i] != switch[i]) begin
        if (cnt[i] == LAST_CNT) begin
          upd[i] = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced level, counters and the one-cycle update pulses
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cnt     <= '0;
      switch  <= '0;
      changed <= 1'b0;
      rise    <= '0;
    end else begin
      cnt     <= cnt_next;
      switch  <= switch ^ upd;
      changed <= |upd;
      rise    <= upd & sync;
    end
  end

`ifdef SWITCH_DB_EVENT_LATCH_EN
  // Sticky rising-edge accumulator; a rise coinciding with ack is kept
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      evt_bits <= '0;
    end else begin
      evt_bits <= (evt_ack ? '0 : evt_bits) | rise;
    end
  end

  assign evt_valid = |evt_bits;
`else
  logic unused_evt_ack;

  // Event latch not built: outputs tied off, acknowledge ignored
  assign evt_bits       = '0;
  assign evt_valid      = 1'b0;
  assign unused_evt_ack = evt_ack;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce (DB_LIMIT=4, WIDTH=7): directed scenarios plus
// randomized switch bouncing against a window-based behavioural model.
module tb_switch_debounce;

  localparam int unsigned W  = 7;
  localparam int unsigned DB = 4;
`ifdef SWITCH_DB_EVENT_LATCH_EN
  localparam bit EVT_EN = 1'b1;
`else
  localparam bit EVT_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] switch;
  logic         changed;
  logic [W-1:0] rise;
  logic [W-1:0] evt_bits;
  logic         evt_valid;
  logic         evt_ack;

  int n_pass  = 0;
  int n_total = 0;

  switch_debounce #(
    .WIDTH    (W),
    .DB_LIMIT (DB),
    .CNT_W    (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .switch    (switch),
    .changed   (changed),
    .rise      (rise),
    .evt_bits  (evt_bits),
    .evt_valid (evt_valid),
    .evt_ack   (evt_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a level is accepted once the last DB synchronized
  // samples seen while out of reset all differ from the current output.
  logic [W-1:0] m_dly0    = '0;
  logic [W-1:0] m_dly1    = '0;
  logic [W-1:0] m_hist[$];
  int           m_rel     = 0;
  logic [W-1:0] m_switch  = '0;
  logic [W-1:0] m_rise    = '0;
  logic         m_changed = 1'b0;
  logic [W-1:0] m_evt     = '0;
  logic [W-1:0] m_upd;

  function automatic void model_clear();
    m_dly0    = '0;
    m_dly1    = '0;
    m_hist.delete();
    m_rel     = 0;
    m_switch  = '0;
    m_rise    = '0;
    m_changed = 1'b0;
    m_evt     = '0;
  endfunction

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    if (!rst_n) begin
      model_clear();
    end else begin
      if (m_rel < 1000) m_rel++;
      if (m_rel >= 3) begin
        m_hist.push_back(m_dly1);
        if (m_hist.size() > DB) void'(m_hist.pop_front());
        m_upd = '0;
        if (m_hist.size() == DB) begin
          for (int b = 0; b < W; b++) begin
            m_upd[b] = 1'b1;
            for (int k = 0; k < DB; k++)
              if (m_hist[k][b] == m_switch[b]) m_upd[b] = 1'b0;
          end
        end
        if (EVT_EN) m_evt = (evt_ack ? '0 : m_evt) | m_rise;
        m_rise    = m_upd & ~m_switch;
        m_changed = |m_upd;
        m_switch  = m_switch ^ m_upd;
      end
      m_dly1 = m_dly0;
      m_dly0 = sw_raw;
    end
  end

  // Continuous comparison against the model, away from the rising edge
  always @(negedge clk) begin
    check("m_switch",    32'(switch),    32'(m_switch));
    check("m_changed",   32'(changed),   32'(m_changed));
    check("m_rise",      32'(rise),      32'(m_rise));
    check("m_evt_bits",  32'(evt_bits),  32'(m_evt));
    check("m_evt_valid", 32'(evt_valid), 32'(m_evt != '0));
  end

  logic seen;

  initial begin
    sw_raw  = '0;
    evt_ack = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_switch",  32'(switch),    32'h0);
    check("rst_changed", 32'(changed),   32'h0);
    check("rst_rise",    32'(rise),      32'h0);
    check("rst_evt",     32'(evt_bits),  32'h0);
    check("rst_valid",   32'(evt_valid), 32'h0);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single bit step: accepted on the sixth edge, one-cycle pulses
    sw_raw = 7'h01;
    repeat (5) @(negedge clk);
    check("t1_early_switch", 32'(switch), 32'h0);
    @(negedge clk);
    check("t1_switch",  32'(switch),  32'h01);
    check("t1_changed", 32'(changed), 32'h1);
    check("t1_rise",    32'(rise),    32'h01);
    @(negedge clk);
    check("t1_changed_end", 32'(changed),  32'h0);
    check("t1_rise_end",    32'(rise),     32'h0);
    check("t1_evt",         32'(evt_bits), EVT_EN ? 32'h01 : 32'h0);
    evt_ack = 1'b1;
    @(negedge clk);
    evt_ack = 1'b0;
    sw_raw  = 7'h00;
    repeat (8) @(negedge clk);
    check("t1_back_low", 32'(switch), 32'h0);

    // Three-cycle glitch on bit 3 is rejected
    sw_raw = 7'h08;
    repeat (3) @(negedge clk);
    sw_raw = 7'h00;
    seen   = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | changed | (|rise) | (|switch);
    end
    check("t2_glitch_activity", 32'(seen),   32'h0);
    check("t2_glitch_switch",   32'(switch), 32'h0);

    // Two bits stepping together: one pulse, multi-bit rise
    sw_raw = 7'h41;
    repeat (5) @(negedge clk);
    check("t3_early_switch", 32'(switch), 32'h0);
    @(negedge clk);
    check("t3_switch",  32'(switch),  32'h41);
    check("t3_changed", 32'(changed), 32'h1);
    check("t3_rise",    32'(rise),    32'h41);
    @(negedge clk);
    check("t3_changed_end", 32'(changed),   32'h0);
    check("t3_evt",         32'(evt_bits),  EVT_EN ? 32'h41 : 32'h0);
    check("t3_valid",       32'(evt_valid), EVT_EN ? 32'h1 : 32'h0);

    // Ack coinciding with a fresh rise keeps the new bit
    evt_ack = 1'b1;
    @(negedge clk);
    evt_ack = 1'b0;
    sw_raw  = 7'h00;
    repeat (8) @(negedge clk);
    sw_raw = 7'h01;
    @(negedge clk);
    sw_raw = 7'h03;
    repeat (6) @(negedge clk);
    check("t4_rise", 32'(rise),     32'h02);
    check("t4_evt",  32'(evt_bits), EVT_EN ? 32'h01 : 32'h0);
    evt_ack = 1'b1;
    @(negedge clk);
    evt_ack = 1'b0;
    check("t4_evt_after_ack", 32'(evt_bits),  EVT_EN ? 32'h02 : 32'h0);
    check("t4_valid",         32'(evt_valid), EVT_EN ? 32'h1 : 32'h0);

    // Reset in the middle of a count discards it
    evt_ack = 1'b1;
    @(negedge clk);
    evt_ack = 1'b0;
    sw_raw  = 7'h43;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_switch",  32'(switch),    32'h0);
    check("t5_rst_changed", 32'(changed),   32'h0);
    check("t5_rst_rise",    32'(rise),      32'h0);
    check("t5_rst_evt",     32'(evt_bits),  32'h0);
    check("t5_rst_valid",   32'(evt_valid), 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_early_switch", 32'(switch), 32'h0);
    @(negedge clk);
    check("t5_switch",  32'(switch),  32'h43);
    check("t5_rise",    32'(rise),    32'h43);
    check("t5_changed", 32'(changed), 32'h1);

    // Random bouncing, acks and occasional resets
    repeat (800) begin
      @(negedge clk);
      sw_raw  = sw_raw ^ W'($urandom & $urandom & $urandom);
      evt_ack = ($urandom_range(3) == 0);
      if ($urandom_range(149) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
